// File: rtl/eth_uplink_arbiter_n.sv
// Uplink egress arbiter: one store-and-forward control stream plus NUM_DATA
// cut-through data streams merged onto one AXIS transmit port, packet-atomic.
module eth_uplink_arbiter_n #(
  parameter int DATA_W     = 64,
  parameter int KEEP_W     = DATA_W / 8,
  parameter int NUM_DATA   = 2,
  parameter int CTRL_DEPTH = 512,
  parameter int ARB_MODE   = 1,
  parameter int CNT_W      = 32
) (
  input  logic                         i_crtl_clk,
  input  logic                         i_crtl_rst,

  input  logic                         s_ctrl_axis_tvalid,
  input  logic [DATA_W-1:0]            s_ctrl_axis_tdata,
  input  logic [KEEP_W-1:0]            s_ctrl_axis_tkeep,
  input  logic                         s_ctrl_axis_tlast,
  input  logic                         s_ctrl_axis_tuser,
  output logic                         s_ctrl_axis_tready,

  input  logic [NUM_DATA-1:0]          s_data_axis_tvalid,
  input  logic [NUM_DATA*DATA_W-1:0]   s_data_axis_tdata,
  input  logic [NUM_DATA*KEEP_W-1:0]   s_data_axis_tkeep,
  input  logic [NUM_DATA-1:0]          s_data_axis_tlast,
  input  logic [NUM_DATA-1:0]          s_data_axis_tuser,
  output logic [NUM_DATA-1:0]          s_data_axis_tready,

  output logic                         m_tx_axis_tvalid,
  output logic [DATA_W-1:0]            m_tx_axis_tdata,
  output logic [KEEP_W-1:0]            m_tx_axis_tkeep,
  output logic                         m_tx_axis_tlast,
  output logic                         m_tx_axis_tuser,
  input  logic                         m_tx_axis_tready,

  output logic [NUM_DATA:0]            o_grant,
  output logic [$clog2(CTRL_DEPTH):0]  o_ctrl_pkt_pending,
  output logic                         o_ctrl_drop,
  output logic [CNT_W-1:0]             o_tx_pkt_cnt,
  output logic [CNT_W-1:0]             o_drop_cnt
);

  localparam int AW     = $clog2(CTRL_DEPTH);
  localparam int PTR_W  = AW + 1;
  localparam int WORD_W = DATA_W + KEEP_W + 2;
  localparam int IDX_W  = (NUM_DATA > 1) ? $clog2(NUM_DATA) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CTRL = 2'd1,
    DATA = 2'd2
  } state_t;

  logic [WORD_W-1:0] mem_q [CTRL_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  start_ptr_q, start_ptr_d;
  logic [PTR_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic              discard_q, discard_d;
  logic              run_q, run_d;
  state_t            state_q, state_d;
  logic [NUM_DATA:0] grant_q, grant_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [IDX_W-1:0]  rr_last_q, rr_last_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic              full;
  logic              ctrl_acc;
  logic              ctrl_wr;
  logic              drop_evt;
  logic              pkt_inc;
  logic              pkt_dec;
  logic              ctrl_rd;
  logic              tx_last_hs;
  logic [WORD_W-1:0] head_word;
  logic [DATA_W-1:0] head_data;
  logic [KEEP_W-1:0] head_keep;
  logic              head_last;
  logic              head_user;
  logic              arb_found;
  logic [IDX_W-1:0]  arb_idx;

  // run_q holds the control input off while reset is asserted and for the first edge after
  assign full               = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign s_ctrl_axis_tready = run_q && (!full || discard_q);
  assign ctrl_acc           = s_ctrl_axis_tvalid && s_ctrl_axis_tready;
  assign ctrl_wr            = ctrl_acc && !discard_q;
  assign drop_evt           = full && (pkt_cnt_q == '0) && !discard_q;
  assign pkt_inc            = ctrl_wr && s_ctrl_axis_tlast;

  assign head_word = mem_q[rd_ptr_q[AW-1:0]];
  assign {head_data, head_keep, head_last, head_user} = head_word;

  assign ctrl_rd    = (state_q == CTRL) && m_tx_axis_tready;
  assign pkt_dec    = ctrl_rd && head_last;
  assign tx_last_hs = m_tx_axis_tvalid && m_tx_axis_tready && m_tx_axis_tlast;

  assign o_grant            = grant_q;
  assign o_ctrl_pkt_pending = pkt_cnt_q;
  assign o_ctrl_drop        = drop_evt;
  assign o_tx_pkt_cnt       = tx_cnt_q;
  assign o_drop_cnt         = drop_cnt_q;

  always_ff @(posedge i_crtl_clk) begin
    if (ctrl_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {s_ctrl_axis_tdata, s_ctrl_axis_tkeep,
                                  s_ctrl_axis_tlast, s_ctrl_axis_tuser};
    end
  end

  // A full buffer with no complete packet can never finish: rewind and swallow the rest
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    start_ptr_d = start_ptr_q;
    discard_d   = discard_q;
    rd_ptr_d    = rd_ptr_q;
    pkt_cnt_d   = pkt_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    run_d       = 1'b1;
    if (drop_evt) begin
      wr_ptr_d   = start_ptr_q;
      discard_d  = 1'b1;
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end else if (ctrl_acc) begin
      if (discard_q) begin
        if (s_ctrl_axis_tlast) begin
          discard_d = 1'b0;
        end
      end else begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (s_ctrl_axis_tlast) begin
          start_ptr_d = wr_ptr_q + PTR_W'(1);
        end
      end
    end
    if (ctrl_rd) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({pkt_inc, pkt_dec})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PTR_W'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - PTR_W'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_DATA; i++) begin
      int cand;
      cand = (ARB_MODE == 1) ? int'(rr_last_q) + 1 + i : i;
      if (cand >= NUM_DATA) begin
        cand = cand - NUM_DATA;
      end
      if (!arb_found && s_data_axis_tvalid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    m_tx_axis_tvalid   = 1'b0;
    m_tx_axis_tdata    = '0;
    m_tx_axis_tkeep    = '0;
    m_tx_axis_tlast    = 1'b0;
    m_tx_axis_tuser    = 1'b0;
    s_data_axis_tready = '0;
    unique case (state_q)
      CTRL: begin
        m_tx_axis_tvalid = 1'b1;
        m_tx_axis_tdata  = head_data;
        m_tx_axis_tkeep  = head_keep;
        m_tx_axis_tlast  = head_last;
        m_tx_axis_tuser  = head_user;
      end
      DATA: begin
        m_tx_axis_tvalid          = s_data_axis_tvalid[sel_q];
        m_tx_axis_tdata           = s_data_axis_tdata[sel_q*DATA_W +: DATA_W];
        m_tx_axis_tkeep           = s_data_axis_tkeep[sel_q*KEEP_W +: KEEP_W];
        m_tx_axis_tlast           = s_data_axis_tlast[sel_q];
        m_tx_axis_tuser           = s_data_axis_tuser[sel_q];
        s_data_axis_tready[sel_q] = m_tx_axis_tready;
      end
      default: ;
    endcase
  end

  // Control has strict priority; the round-robin pointer only moves on a data grant
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    rr_last_d = rr_last_q;
    tx_cnt_d  = tx_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pkt_cnt_q != '0) begin
          state_d = CTRL;
          grant_d = (NUM_DATA+1)'(1);
        end else if (arb_found) begin
          state_d   = DATA;
          sel_d     = arb_idx;
          rr_last_d = arb_idx;
          grant_d   = (NUM_DATA+1)'(2) << arb_idx;
        end
      end
      CTRL, DATA: begin
        if (tx_last_hs) begin
          state_d  = IDLE;
          grant_d  = '0;
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_crtl_clk or posedge i_crtl_rst) begin
    if (i_crtl_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      start_ptr_q <= '0;
      pkt_cnt_q   <= '0;
      discard_q   <= 1'b0;
      run_q       <= 1'b0;
      state_q     <= IDLE;
      grant_q     <= '0;
      sel_q       <= '0;
      rr_last_q   <= IDX_W'(NUM_DATA - 1);
      tx_cnt_q    <= '0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      start_ptr_q <= start_ptr_d;
      pkt_cnt_q   <= pkt_cnt_d;
      discard_q   <= discard_d;
      run_q       <= run_d;
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      rr_last_q   <= rr_last_d;
      tx_cnt_q    <= tx_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: doc/eth_uplink_arbiter_n.md
Name: eth_uplink_arbiter_n

Overview:
Parametrised uplink egress arbiter for the 10G port path. It merges one buffered control stream with NUM_DATA cut-through data streams onto a single AXIS transmit interface. Control packets are held in an internal store-and-forward buffer and are released only once complete. Every grant is packet-atomic: the selected source is not changed until its tlast beat has been accepted. Single clock domain; any CDC is done upstream of this block.

Parameters:
DATA_W, 64, tdata width in bits; must be a multiple of 8.
KEEP_W, DATA_W/8, tkeep width.
NUM_DATA, 2, number of cut-through data inputs; range 1..8.
CTRL_DEPTH, 512, control buffer depth in words; must be a power of 2.
ARB_MODE, 1, data-input arbitration: 0 = fixed priority (lowest index wins), 1 = round-robin.
CNT_W, 32, width of the statistics counters.

Ports:
i_crtl_clk  in  1  clock
i_crtl_rst  in  1  asynchronous reset, active-high
s_ctrl_axis_tvalid/tdata/tkeep/tlast/tuser  in  1/DATA_W/KEEP_W/1/1  control packet input
s_ctrl_axis_tready  out  1  control input ready
s_data_axis_tvalid  in  NUM_DATA  per-channel valid
s_data_axis_tdata  in  NUM_DATA*DATA_W  packed data; channel i occupies bits [i*DATA_W +: DATA_W]
s_data_axis_tkeep  in  NUM_DATA*KEEP_W  packed keep
s_data_axis_tlast  in  NUM_DATA  per-channel last
s_data_axis_tuser  in  NUM_DATA  per-channel user
s_data_axis_tready  out  NUM_DATA  per-channel ready
m_tx_axis_tvalid/tdata/tkeep/tlast/tuser  out  1/DATA_W/KEEP_W/1/1  merged output
m_tx_axis_tready  in  1  output ready
o_grant  out  NUM_DATA+1  one-hot current owner; bit 0 = control, bit i+1 = data channel i; all zero when idle
o_ctrl_pkt_pending  out  log2(CTRL_DEPTH)+1  number of complete control packets held in the buffer
o_ctrl_drop  out  1  one-cycle pulse when an oversize control packet is discarded
o_tx_pkt_cnt  out  CNT_W  packets transmitted; wraps
o_drop_cnt  out  CNT_W  control packets dropped; wraps

Behaviour:
- Reset (async assert, sync release): FSM returns to IDLE and the buffer is flushed (pointers and packet count = 0). All of the following are 0: m_tx_axis_tvalid, s_ctrl_axis_tready, s_data_axis_tready, o_grant, o_ctrl_drop, both counters. An in-flight packet is abandoned with no tlast emitted.
- Control buffer storage:
  - Each word stores {tdata, tkeep, tlast, tuser}.
  - Write and read pointers are log2(CTRL_DEPTH)+1 bits wide, and wrap naturally.
  - full = (MSBs differ && lower bits equal).
  - s_ctrl_axis_tready = !full || discarding.
  - Read is first-word-fall-through; the head word is presented combinationally.
- Control packet accounting:
  - The buffer tracks a packet-start pointer.
  - On an accepted tlast, the packet count increments and the start pointer moves to the write pointer.
  - The packet count decrements on the output handshake of a control tlast beat.
  - If both happen in the same cycle, the count is unchanged.
- Oversize control packet: if full && packet count == 0, the buffer cannot complete a packet, so:
  - the write pointer rewinds to the start pointer and o_ctrl_drop pulses for 1 cycle;
  - o_drop_cnt increments;
  - the block enters the discarding state, in which it accepts and drops words up to and including tlast.
  - Control packets must therefore be at most CTRL_DEPTH words long to be forwarded.
- FSM states IDLE, CTRL, DATA; the state and grant are registered.
- IDLE:
  - If packet count != 0, go to CTRL. Control has strict priority.
  - Otherwise, if any s_data_axis_tvalid is set, go to DATA with a grant:
    - ARB_MODE 0: lowest asserted index.
    - ARB_MODE 1: first asserted index searching upward from (last granted + 1) mod NUM_DATA. The round-robin pointer updates only when a DATA grant is issued.
  - Otherwise stay in IDLE.
- CTRL:
  - m_tx_axis_tvalid = 1 and the outputs come from the buffer head.
  - The read pointer advances on m_tx_axis_tready.
  - On the tlast handshake: go to IDLE and o_tx_pkt_cnt++.
- DATA:
  - The outputs are muxed from the granted channel.
  - Granted s_data_axis_tready = m_tx_axis_tready; all other channels' tready = 0.
  - On the tlast handshake: go to IDLE and o_tx_pkt_cnt++.
- Latency and timing:
  - 1 cycle from request seen in IDLE to first m_tx_axis_tvalid.
  - There is exactly one idle bubble cycle between consecutive packets.
  - Output tvalid is never asserted in IDLE.
- The output holds stable while tvalid && !tready (AXIS rule). Input valid dropping mid-packet in DATA simply stalls the output.
- Control writes continue independently during DATA and CTRL states. A simultaneous write and read in the same cycle is allowed.

Test Plan:
1. Control pkt of 4 words, data idle, tready=1 → o_grant=0b001; 4 output beats with tlast on beat 4 matching the input keep; o_tx_pkt_cnt=1; pending back to 0.
2. NUM_DATA=2, ARB_MODE=1, both channels continuously sending 3-word pkts → grants alternate ch0, ch1, ch0 with 1 bubble between; non-granted tready=0 throughout.
3. Control pkt completes while ch1 is mid-packet → ch1 pkt finishes intact; next grant = control, even though ch0 is valid.
4. CTRL_DEPTH=16, 20-word control pkt → o_ctrl_drop pulses once; o_drop_cnt=1; remaining 4 words accepted and dropped; a following 3-word pkt is forwarded intact.
5. m_tx_axis_tready toggled randomly during a CTRL pkt → no duplicated or lost beats; data matches the input order.
6. Reset asserted mid-DATA packet → all outputs 0 immediately; after release, pending=0 and a new control pkt is forwarded normally.
